qwi_axil2reg: RTL and testbench
===============================

QWI_AXIL2REG -- requirements
Module: qwi_axil2reg

Interface
REQ-001 The block SHALL have a single clock domain, with a synchronous, active-high reset. Ports reg_clk and reg_rst are listed below.
REQ-002 Parameter REGCNT, default 32: number of implemented 32-bit registers downstream.
REQ-003 Parameter AWID, default 12: word-address width of the register bus.
REQ-004 Parameter DWID, default 32: data width; AXI strobe width DWID/8.
REQ-005 reg_clk  in  1  clock for AXI slave and register bus.
REQ-006 reg_rst  in  1  synchronous active-high reset.
REQ-007 s_axil_awaddr  in  AWID+2  byte write address; s_axil_awvalid in 1; s_axil_awready out 1.
REQ-008 s_axil_wdata  in  DWID; s_axil_wstrb in DWID/8; s_axil_wvalid in 1; s_axil_wready out 1.
REQ-009 s_axil_bresp  out  2; s_axil_bvalid out 1; s_axil_bready in 1.
REQ-010 s_axil_araddr  in  AWID+2  byte read address; s_axil_arvalid in 1; s_axil_arready out 1.
REQ-011 s_axil_rdata  out  DWID; s_axil_rresp out 2; s_axil_rvalid out 1; s_axil_rready in 1.
REQ-012 reg_ce  out  1  register-bus access enable.
REQ-013 reg_we  out  DWID/8  byte write enables, valid only with reg_ce.
REQ-014 reg_addr  out  AWID  register word index.
REQ-015 reg_wrd  out  DWID  write data.
REQ-016 reg_rdd  in  DWID  read data, combinational function of reg_addr.

Function
REQ-017 The FSM SHALL use states IDLE, WR_EXEC, WR_RESP, RD_ADDR, RD_DATA.
REQ-018 Word index = axaddr[AWID+1:2]; axaddr[1:0] ignored.
REQ-019 awready = wready = (IDLE && awvalid && wvalid); AW and W handshake in the same cycle; a lone AW or W is never accepted.
REQ-020 arready = (IDLE && arvalid && !(awvalid && wvalid)); write wins when both are pending in the same IDLE cycle.
REQ-021 On write handshake: capture address, data and strobe into reg_addr/reg_wrd/internal strobe; next state WR_EXEC.
REQ-022 WR_EXEC (1 cycle): if legal, reg_ce=1, reg_we=captured strobe; otherwise reg_ce=0, reg_we=0; next state WR_RESP.
REQ-023 A write is legal iff index < REGCNT and the strobe is all-ones; illegal -> bresp=2'b10 (SLVERR), no bus write; legal -> bresp=2'b00.
REQ-024 WR_RESP: bvalid=1, bresp stable, until bready; on bvalid&&bready -> IDLE; bvalid rises exactly 2 cycles after the AW/W handshake cycle.
REQ-025 On read handshake: capture index into reg_addr; next state RD_ADDR; reg_ce=0 throughout reads.
REQ-026 RD_ADDR (1 cycle): at its end register rdata = reg_rdd if index < REGCNT, else 0; rresp 2'b00 or 2'b10 accordingly; next state RD_DATA.
REQ-027 RD_DATA: rvalid=1, rdata/rresp stable until rready; on rvalid&&rready -> IDLE; rvalid rises exactly 2 cycles after the AR handshake.
REQ-028 Only one transaction is outstanding at a time; no ready is asserted outside IDLE.
REQ-029 reg_ce SHALL be high for at most one cycle per write and never on consecutive cycles.
REQ-030 reg_addr and reg_wrd SHALL hold their last captured values between transactions.
REQ-031 Back-to-back: minimum write period is 3 cycles (bready held high); the next handshake may occur in the cycle after the B handshake.

Reset
REQ-032 reg_rst SHALL be sampled on the rising edge of reg_clk and take priority over all other inputs.
REQ-033 While reg_rst is high, the FSM SHALL be held in IDLE and all outputs forced to zero, including all readies, bvalid, rvalid, bresp, rresp, rdata, reg_ce, reg_we, reg_addr and reg_wrd.
REQ-034 Reset mid-transaction SHALL abandon the transaction without issuing a response, and any pending reg_ce SHALL be suppressed.
REQ-035 Readies SHALL be 0 in the cycle reg_rst is high.

Structure
REQ-036 The response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 and the FSM state encodings SHALL be defined in the shared Define.vh.
REQ-037 The block SHALL be a single module with no sub-modules.
REQ-038 The block SHALL instantiate directly upstream of qwi_regctrl, sharing reg_clk, with its reg_rst tied to the same reset.

Verification
REQ-039 Legal write: awaddr=0x008, wdata=0xA5A5_0001, wstrb=0xF, bready=1 -> reg_ce pulse with reg_addr=2 and reg_we=0xF 1 cycle after handshake; bvalid 2 cycles after; bresp=00.
REQ-040 Read-back: araddr=0x008 with the downstream register holding 0xA5A5_0001 -> rvalid 2 cycles after AR handshake; rdata=0xA5A5_0001; rresp=00.
REQ-041 Illegal accesses: wstrb=0x3 or awaddr=4*REGCNT -> no reg_ce, bresp=10; araddr=4*REGCNT -> rdata=0, rresp=10.
REQ-042 Simultaneous AW+W+AR in IDLE -> write accepted first, arready=0 that cycle; read accepted after the B handshake; bready/rready held low 5 cycles -> bvalid/rvalid and their data held stable.
REQ-043 Lone AW without W held 10 cycles -> awready stays 0 and no reg_ce occurs; W then asserted -> normal write.
REQ-044 reg_rst asserted in WR_EXEC cycle -> reg_ce=0 that cycle, no bvalid afterward, FSM in IDLE with all outputs 0 on the next cycle.

Source files
------------

// File: rtl/qwi_axil2reg_pkg.sv
// Shared definitions for the AXI4-Lite to register-bus bridge:
// FSM state encoding and AXI response codes.
package qwi_axil2reg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_EXEC = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/qwi_axil2reg.sv
// AXI4-Lite slave bridging single-beat reads/writes onto a simple register bus
// (one outstanding transaction, 2-cycle request-to-response latency).
module qwi_axil2reg
    import qwi_axil2reg_pkg::*;
#(
    parameter int REGCNT = 32,
    parameter int AWID   = 12,
    parameter int DWID   = 32
) (
    input  logic                reg_clk,
    input  logic                reg_rst,
    input  logic [AWID+1:0]     s_axil_awaddr,
    input  logic                s_axil_awvalid,
    output logic                s_axil_awready,
    input  logic [DWID-1:0]     s_axil_wdata,
    input  logic [DWID/8-1:0]   s_axil_wstrb,
    input  logic                s_axil_wvalid,
    output logic                s_axil_wready,
    output logic [1:0]          s_axil_bresp,
    output logic                s_axil_bvalid,
    input  logic                s_axil_bready,
    input  logic [AWID+1:0]     s_axil_araddr,
    input  logic                s_axil_arvalid,
    output logic                s_axil_arready,
    output logic [DWID-1:0]     s_axil_rdata,
    output logic [1:0]          s_axil_rresp,
    output logic                s_axil_rvalid,
    input  logic                s_axil_rready,
    output logic                reg_ce,
    output logic [DWID/8-1:0]   reg_we,
    output logic [AWID-1:0]     reg_addr,
    output logic [DWID-1:0]     reg_wrd,
    input  logic [DWID-1:0]     reg_rdd
);

    localparam int SWID = DWID / 8;
    localparam logic [AWID:0] REGCNT_W = REGCNT[AWID:0];

    state_t            state_reg;
    logic [AWID-1:0]   addr_reg;
    logic [DWID-1:0]   wrd_reg;
    logic [SWID-1:0]   strb_reg;
    logic              ce_reg;
    logic [1:0]        bresp_reg;
    logic              bvalid_reg;
    logic [DWID-1:0]   rdata_reg;
    logic [1:0]        rresp_reg;
    logic              rvalid_reg;

    logic [AWID-1:0]   aw_idx;
    logic [AWID-1:0]   ar_idx;
    logic              wr_hs;
    logic              rd_hs;
    logic              wr_legal;
    logic              rd_in_range;
    logic              unused_addr_bits;

    assign aw_idx = s_axil_awaddr[AWID+1:2];
    assign ar_idx = s_axil_araddr[AWID+1:2];
    assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // AW and W must arrive together; a pending write beats a pending read.
    assign wr_hs = !reg_rst && (state_reg == IDLE) && s_axil_awvalid && s_axil_wvalid;
    assign rd_hs = !reg_rst && (state_reg == IDLE) && s_axil_arvalid
                   && !(s_axil_awvalid && s_axil_wvalid);

    assign wr_legal    = ({1'b0, aw_idx} < REGCNT_W) && (&s_axil_wstrb);
    assign rd_in_range = ({1'b0, addr_reg} < REGCNT_W);

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            wrd_reg    <= '0;
            strb_reg   <= '0;
            ce_reg     <= 1'b0;
            bresp_reg  <= RESP_OKAY;
            bvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
            rvalid_reg <= 1'b0;
        end else begin
            ce_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_hs) begin
                        addr_reg  <= aw_idx;
                        wrd_reg   <= s_axil_wdata;
                        strb_reg  <= s_axil_wstrb;
                        ce_reg    <= wr_legal;
                        bresp_reg <= wr_legal ? RESP_OKAY : RESP_SLVERR;
                        state_reg <= WR_EXEC;
                    end else if (rd_hs) begin
                        addr_reg  <= ar_idx;
                        state_reg <= RD_ADDR;
                    end
                end
                WR_EXEC: begin
                    bvalid_reg <= 1'b1;
                    state_reg  <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axil_bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                RD_ADDR: begin
                    // reg_rdd has settled on addr_reg during this cycle.
                    rdata_reg  <= rd_in_range ? reg_rdd : '0;
                    rresp_reg  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rvalid_reg <= 1'b1;
                    state_reg  <= RD_DATA;
                end
                RD_DATA: begin
                    if (s_axil_rready) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Outputs are masked by reset so a mid-transaction reset kills them in the same cycle.
    assign s_axil_awready = wr_hs;
    assign s_axil_wready  = wr_hs;
    assign s_axil_arready = rd_hs;
    assign s_axil_bvalid  = bvalid_reg && !reg_rst;
    assign s_axil_bresp   = reg_rst ? RESP_OKAY : bresp_reg;
    assign s_axil_rvalid  = rvalid_reg && !reg_rst;
    assign s_axil_rresp   = reg_rst ? RESP_OKAY : rresp_reg;
    assign s_axil_rdata   = reg_rst ? '0 : rdata_reg;
    assign reg_ce         = ce_reg && !reg_rst;
    assign reg_we         = (ce_reg && !reg_rst) ? strb_reg : '0;
    assign reg_addr       = reg_rst ? '0 : addr_reg;
    assign reg_wrd        = reg_rst ? '0 : wrd_reg;

endmodule

// File: tb/tb_qwi_axil2reg.sv
// Scoreboard bench for qwi_axil2reg: drivers push expected responses, a
// negedge monitor pops and compares them as the DUT presents them.
module tb_qwi_axil2reg;
    import qwi_axil2reg_pkg::*;

    localparam int REGCNT = 32;
    localparam int AWID   = 12;
    localparam int DWID   = 32;

    logic              reg_clk = 1'b0;
    logic              reg_rst = 1'b1;
    logic [AWID+1:0]   s_axil_awaddr = '0;
    logic              s_axil_awvalid = 1'b0;
    logic              s_axil_awready;
    logic [DWID-1:0]   s_axil_wdata = '0;
    logic [3:0]        s_axil_wstrb = '0;
    logic              s_axil_wvalid = 1'b0;
    logic              s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid;
    logic              s_axil_bready = 1'b0;
    logic [AWID+1:0]   s_axil_araddr = '0;
    logic              s_axil_arvalid = 1'b0;
    logic              s_axil_arready;
    logic [DWID-1:0]   s_axil_rdata;
    logic [1:0]        s_axil_rresp;
    logic              s_axil_rvalid;
    logic              s_axil_rready = 1'b0;
    logic              reg_ce;
    logic [3:0]        reg_we;
    logic [AWID-1:0]   reg_addr;
    logic [DWID-1:0]   reg_wrd;
    logic [DWID-1:0]   reg_rdd;

    qwi_axil2reg #(.REGCNT(REGCNT), .AWID(AWID), .DWID(DWID)) dut (
        .reg_clk(reg_clk), .reg_rst(reg_rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wrd(reg_wrd), .reg_rdd(reg_rdd)
    );

    always #5 reg_clk = ~reg_clk;

    int cyc = 0;
    always @(posedge reg_clk) cyc <= cyc + 1;

    // Downstream register file stand-in; out-of-range reads return junk.
    logic [31:0] dn_mem [REGCNT];
    always @(posedge reg_clk) begin
        if (reg_ce) begin
            for (int b = 0; b < 4; b++)
                if (reg_we[b]) dn_mem[reg_addr[4:0]][8*b +: 8] <= reg_wrd[8*b +: 8];
        end
    end
    assign reg_rdd = ({20'b0, reg_addr} < 32'(REGCNT)) ? dn_mem[reg_addr[4:0]] : 32'hDEAD_BEEF;

    // Reference model of the register contents as seen through the AXI port.
    logic [31:0] ref_mem [REGCNT];

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } ce_t;

    exp_t sb_q[$];
    ce_t  ce_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int last_b_cyc = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [89:0] all_outputs();
        return {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp, s_axil_arready,
                s_axil_rvalid, s_axil_rresp, s_axil_rdata, reg_ce, reg_we, reg_addr, reg_wrd};
    endfunction

    task automatic push_rd(input logic [11:0] idx);
        exp_t e;
        e.is_rd = 1'b1;
        if (idx < 12'(REGCNT)) begin
            e.data = ref_mem[idx[4:0]];
            e.resp = RESP_OKAY;
        end else begin
            e.data = 32'h0;
            e.resp = RESP_SLVERR;
        end
        sb_q.push_back(e);
    endtask

    // Monitor: response/bus-write scoreboard plus hold-while-stalled checks.
    bit          prev_bv = 0, prev_br = 0, prev_rv = 0, prev_rr = 0, prev_ce = 0;
    logic [1:0]  prev_bresp = 0, prev_rresp = 0;
    logic [31:0] prev_rdata = 0;
    always @(negedge reg_clk) begin
        exp_t e;
        ce_t  c;
        if (!reg_rst) begin
            if (prev_bv && !prev_br)
                check(s_axil_bvalid && s_axil_bresp == prev_bresp, "b_hold",
                      {s_axil_bvalid, s_axil_bresp}, {1'b1, prev_bresp});
            if (prev_rv && !prev_rr)
                check(s_axil_rvalid && s_axil_rdata == prev_rdata && s_axil_rresp == prev_rresp, "r_hold",
                      {s_axil_rvalid, s_axil_rresp, s_axil_rdata}, {1'b1, prev_rresp, prev_rdata});
            if (s_axil_bvalid && s_axil_bready) begin
                if (sb_q.size() == 0) check(1'b0, "b_unexpected", 64'(s_axil_bresp), 64'(sb_q.size()));
                else begin
                    e = sb_q.pop_front();
                    check(!e.is_rd && s_axil_bresp == e.resp, "bresp", {e.is_rd, s_axil_bresp}, {1'b0, e.resp});
                    $display("[TB] cyc %0d WR bresp=%b", cyc, s_axil_bresp);
                end
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (sb_q.size() == 0) check(1'b0, "r_unexpected", 64'(s_axil_rdata), 64'(sb_q.size()));
                else begin
                    e = sb_q.pop_front();
                    check(e.is_rd && s_axil_rdata == e.data && s_axil_rresp == e.resp, "rdata_rresp",
                          {e.is_rd, s_axil_rresp, s_axil_rdata}, {1'b1, e.resp, e.data});
                    $display("[TB] cyc %0d RD rdata=%h rresp=%b", cyc, s_axil_rdata, s_axil_rresp);
                end
            end
            if (reg_ce) begin
                check(!prev_ce, "ce_consecutive", 64'(prev_ce), 64'(0));
                if (ce_q.size() == 0) check(1'b0, "ce_unexpected", 64'(reg_addr), 64'(ce_q.size()));
                else begin
                    c = ce_q.pop_front();
                    check(reg_addr == c.addr && reg_wrd == c.data && reg_we == c.we, "bus_write",
                          {reg_we, reg_addr, reg_wrd}, {c.we, c.addr, c.data});
                end
            end
        end
        prev_bv = s_axil_bvalid; prev_br = s_axil_bready; prev_bresp = s_axil_bresp;
        prev_rv = s_axil_rvalid; prev_rr = s_axil_rready; prev_rresp = s_axil_rresp;
        prev_rdata = s_axil_rdata; prev_ce = reg_ce;
    end

    task automatic do_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bdelay, input bit with_ar, input logic [13:0] ar, input int expect_hs);
        logic [11:0] idx;
        bit legal, got;
        int hs;
        exp_t e;
        ce_t c;
        idx   = a[13:2];
        legal = (idx < 12'(REGCNT)) && (s == 4'hF);
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        s_axil_bready = (bdelay == 0);
        e.is_rd = 1'b0; e.data = 32'h0; e.resp = legal ? RESP_OKAY : RESP_SLVERR;
        sb_q.push_back(e);
        if (legal) begin
            c.addr = idx; c.data = d; c.we = s;
            ce_q.push_back(c);
            ref_mem[idx[4:0]] = d;
        end
        if (with_ar) begin
            s_axil_araddr = ar; s_axil_arvalid = 1'b1;
            push_rd(ar[13:2]);
        end
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge reg_clk);
            if (s_axil_awready && s_axil_wready) begin got = 1; break; end
        end
        check(got, "aw_w_accept", 64'(got), 64'(1));
        if (with_ar) check(!s_axil_arready, "ar_blocked_by_write", 64'(s_axil_arready), 64'(0));
        @(posedge reg_clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        hs = cyc;
        if (expect_hs >= 0) check(hs == expect_hs, "wr_back_to_back", 64'(hs), 64'(expect_hs));
        @(negedge reg_clk);
        check(reg_ce == legal, "ce_after_handshake", 64'(reg_ce), 64'(legal));
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge reg_clk);
            if (s_axil_bvalid) begin got = 1; break; end
        end
        check(got && cyc == hs + 1, "b_latency", 64'(cyc - hs + 1), 64'(2));
        if (bdelay > 0) begin
            repeat (bdelay) begin @(posedge reg_clk); #1; end
            s_axil_bready = 1'b1;
        end
        @(posedge reg_clk); #1;
        last_b_cyc = cyc;
        s_axil_bready = 1'b0;
    endtask

    task automatic do_read(input logic [13:0] a, input int rdelay, input int expect_hs, input bit push);
        bit got;
        int hs;
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        s_axil_rready = (rdelay == 0);
        if (push) push_rd(a[13:2]);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge reg_clk);
            if (s_axil_arready) begin got = 1; break; end
        end
        check(got, "ar_accept", 64'(got), 64'(1));
        @(posedge reg_clk); #1;
        s_axil_arvalid = 1'b0;
        hs = cyc;
        if (expect_hs >= 0) check(hs == expect_hs, "rd_after_b", 64'(hs), 64'(expect_hs));
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge reg_clk);
            if (s_axil_rvalid) begin got = 1; break; end
        end
        check(got && cyc == hs + 1, "r_latency", 64'(cyc - hs + 1), 64'(2));
        if (rdelay > 0) begin
            repeat (rdelay) begin @(posedge reg_clk); #1; end
            s_axil_rready = 1'b1;
        end
        @(posedge reg_clk); #1;
        s_axil_rready = 1'b0;
    endtask

    initial begin
        logic [11:0] ridx;
        logic [3:0]  rs;
        bit          got;
        for (int i = 0; i < REGCNT; i++) begin
            dn_mem[i]  = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // Reset with all valids asserted: every output and ready must stay zero.
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        repeat (3) @(posedge reg_clk);
        @(negedge reg_clk);
        check(all_outputs() == '0, "reset_outputs_zero", 64'(|all_outputs()), 64'(0));
        check(!s_axil_awready && !s_axil_arready, "reset_readies", {s_axil_awready, s_axil_arready}, 64'(0));
        @(posedge reg_clk); #1;
        reg_rst = 1'b0;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        @(posedge reg_clk); #1;

        // Basic legal write and read-back.
        do_write(14'h008, 32'hA5A5_0001, 4'hF, 0, 1'b0, 14'h0, -1);
        do_read(14'h008, 0, -1, 1'b1);

        // Back-to-back writes with bready high: period of 3 cycles.
        do_write(14'h010, 32'h1111_2222, 4'hF, 0, 1'b0, 14'h0, -1);
        do_write(14'h014, 32'h3333_4444, 4'hF, 0, 1'b0, 14'h0, last_b_cyc + 1);

        // Illegal accesses: partial strobe, out-of-range write and read.
        do_write(14'h00C, 32'hBAD0_0003, 4'h3, 1, 1'b0, 14'h0, -1);
        do_write(14'(4 * REGCNT), 32'hBAD0_0080, 4'hF, 0, 1'b0, 14'h0, -1);
        do_read(14'(4 * REGCNT), 2, -1, 1'b1);
        do_read(14'h00C, 0, -1, 1'b1);

        // Simultaneous AW+W+AR with both responses stalled for 5 cycles.
        do_write(14'h018, 32'hCAFE_0006, 4'hF, 5, 1'b1, 14'h008, -1);
        do_read(14'h008, 5, last_b_cyc + 1, 1'b0);

        // Lone AW must never be accepted.
        s_axil_awaddr = 14'h01C; s_axil_awvalid = 1'b1;
        got = 1'b0;
        repeat (10) begin
            @(negedge reg_clk);
            if (s_axil_awready || s_axil_wready || reg_ce) got = 1'b1;
        end
        check(!got, "lone_aw_ignored", 64'(got), 64'(0));
        @(posedge reg_clk); #1;
        do_write(14'h01C, 32'h0BAD_F00D, 4'hF, 0, 1'b0, 14'h0, -1);
        do_read(14'h01C, 1, -1, 1'b1);

        // Reset during WR_EXEC: no bus write, no response, all outputs cleared.
        s_axil_awaddr = 14'h014; s_axil_wdata = 32'hDEAD_0005; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge reg_clk);
            if (s_axil_awready) begin got = 1'b1; break; end
        end
        check(got, "rst_test_accept", 64'(got), 64'(1));
        @(posedge reg_clk); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        reg_rst = 1'b1;
        @(negedge reg_clk);
        check(!reg_ce, "ce_suppressed_by_reset", 64'(reg_ce), 64'(0));
        @(posedge reg_clk); #1;
        reg_rst = 1'b0;
        @(negedge reg_clk);
        check(all_outputs() == '0, "post_reset_outputs_zero", 64'(|all_outputs()), 64'(0));
        got = 1'b0;
        repeat (6) begin
            @(negedge reg_clk);
            if (s_axil_bvalid) got = 1'b1;
        end
        check(!got, "no_b_after_reset", 64'(got), 64'(0));
        @(posedge reg_clk); #1;
        s_axil_bready = 1'b0;
        do_read(14'h014, 0, -1, 1'b1);

        // Randomized mix against the reference model.
        for (int n = 0; n < 40; n++) begin
            ridx = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, REGCNT + 3));
            rs   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 1) == 1)
                do_write({ridx, 2'($urandom)}, $urandom, rs, int'($urandom_range(0, 3)), 1'b0, 14'h0, -1);
            else
                do_read({ridx, 2'($urandom)}, int'($urandom_range(0, 3)), -1, 1'b1);
        end

        repeat (5) @(posedge reg_clk);
        @(negedge reg_clk);
        check(sb_q.size() == 0, "responses_drained", 64'(sb_q.size()), 64'(0));
        check(ce_q.size() == 0, "bus_writes_drained", 64'(ce_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
